// File: rtl/set_assoc_icache_pkg.sv
// set_assoc_icache_pkg: shared refill state encoding and cache geometry helpers
package set_assoc_icache_pkg;
  typedef enum logic {IDLE, REFILL} state_e;
  function automatic int tag_bit(input int index_bit, input int offset_bit);
    return 30 - index_bit - offset_bit;
  endfunction
  function automatic int line_words(input int offset_bit);
    return 1 << offset_bit;
  endfunction
endpackage

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: refill FSM, word address generation and victim latch; mem_addr doubles as the latched line base and word counter
module icache_refill_ctrl
  import set_assoc_icache_pkg::*;
#(
  parameter int IndexBit = 4,
  parameter int OffsetBit = 2,
  parameter int Ways = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush,
  input  logic                 miss,
  input  logic                 mem_ack,
  input  logic [29-OffsetBit:0] line_addr,
  input  logic                 v0,
  input  logic                 v1,
  input  logic                 lru_way,
  output state_e               state,
  output logic                 mem_req,
  output logic [31:0]          mem_addr,
  output logic                 start,
  output logic                 wr_en,
  output logic                 last,
  output logic                 victim,
  output logic                 victim_sel
);
  state_e state_n;
  logic [31:0] addr_n;
  logic victim_n;
  assign mem_req = state == REFILL;
  assign victim_sel = (Ways == 1 || !v0) ? 1'b0 : !v1 ? 1'b1 : lru_way;
  // next state, next word address and victim capture
  always_comb begin
    start = rdy_in && !flush && state == IDLE && miss;
    wr_en = rdy_in && !flush && state == REFILL && mem_ack;
    last = wr_en && &mem_addr[1+OffsetBit:2];
    state_n = ((rdy_in && flush) || last) ? IDLE : start ? REFILL : state;
    addr_n = start ? {line_addr, {(OffsetBit + 2){1'b0}}} : (wr_en && !last) ? mem_addr + 32'd4 : mem_addr;
    victim_n = start ? victim_sel : victim;
  end
  // refill state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      mem_addr <= '0;
      victim <= 1'b0;
    end else begin
      state <= state_n;
      mem_addr <= addr_n;
      victim <= victim_n;
    end
  end
endmodule

// File: rtl/set_assoc_icache.sv
// set_assoc_icache: 1/2-way set-associative instruction cache with LRU and autonomous line refill
module set_assoc_icache
  import set_assoc_icache_pkg::*;
#(
  parameter int IndexBit = 4,
  parameter int OffsetBit = 2,
  parameter int Ways = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        hit,
  output logic [31:0] fetch_inst,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data
);
  localparam int TagBit = tag_bit(IndexBit, OffsetBit);
  localparam int LineWords = line_words(OffsetBit);
  localparam int Sets = 1 << IndexBit;
  logic [Sets-1:0] valid [Ways];
  logic [Sets-1:0] lru;
  logic [TagBit-1:0] tags [Ways][Sets];
  logic [31:0] data [Ways][Sets][LineWords];
  logic [Ways-1:0] way_hit;
  logic [IndexBit-1:0] idx, r_idx;
  logic [TagBit-1:0] tag, r_tag;
  logic [OffsetBit-1:0] word, cnt;
  logic hit_way, start, wr_en, last, victim, victim_sel, unused_ok;
  state_e state;
  assign unused_ok = &{1'b0, fetch_addr[1:0]};
  assign idx = fetch_addr[1+OffsetBit+IndexBit:2+OffsetBit];
  assign tag = fetch_addr[31:2+OffsetBit+IndexBit];
  assign word = fetch_addr[1+OffsetBit:2];
  assign r_idx = mem_addr[1+OffsetBit+IndexBit:2+OffsetBit];
  assign r_tag = mem_addr[31:2+OffsetBit+IndexBit];
  assign cnt = mem_addr[1+OffsetBit:2];
  genvar w;
  generate
    for (w = 0; w < Ways; w++) begin : g_way
      assign way_hit[w] = valid[w][idx] && tags[w][idx] == tag;
    end
  endgenerate
  assign hit_way = Ways == 2 && way_hit[Ways-1];
  assign hit = fetch_valid && state == IDLE && |way_hit;
  assign fetch_inst = hit ? data[hit_way][idx][word] : '0;
  icache_refill_ctrl #(.IndexBit(IndexBit), .OffsetBit(OffsetBit), .Ways(Ways)) u_ctrl (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .flush(flush),
    .miss(fetch_valid && !hit),
    .mem_ack(mem_ack),
    .line_addr(fetch_addr[31:2+OffsetBit]),
    .v0(valid[0][idx]),
    .v1(valid[Ways-1][idx]),
    .lru_way(lru[idx]),
    .state(state),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .start(start),
    .wr_en(wr_en),
    .last(last),
    .victim(victim),
    .victim_sel(victim_sel)
  );
  // valid bits and LRU: flush wins, victim invalidated at refill start, validated on last word
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < Ways; i++) valid[i] <= '0;
      lru <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        for (int i = 0; i < Ways; i++) valid[i] <= '0;
      end else if (start) begin
        valid[victim_sel][idx] <= 1'b0;
      end else if (last) begin
        valid[victim][r_idx] <= 1'b1;
        lru[r_idx] <= !victim;
      end else if (hit) begin
        lru[idx] <= !hit_way;
      end
    end
  end
  // line data and tag storage written by the refill
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      data[victim][r_idx][cnt] <= mem_data;
      if (last) tags[victim][r_idx] <= r_tag;
    end
  end
endmodule

// File: tb/tb_set_assoc_icache.sv
// tb_set_assoc_icache: directed fetch scenarios checked against a line-level cache model
module tb_set_assoc_icache;
  logic clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, flush = 1'b0, fetch_valid = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic hit, mem_req, mem_ack;
  logic [31:0] fetch_inst, mem_addr, mem_data;
  logic auto_ack = 1'b1, man_ack = 1'b0, junk = 1'b0;
  logic f1_valid = 1'b0;
  logic [31:0] f1_addr = '0;
  logic hit1, req1;
  logic [31:0] inst1, addr1;
  int checks = 0, errors = 0, acks = 0;
  bit mv [2][16];
  logic [23:0] mt [2][16];
  logic [31:0] md [2][16][4];
  bit ml [16];
  bit mref = 1'b0, mvic = 1'b0;
  logic [31:0] mbase = '0;
  int mcnt = 0;
  always #5 clk_in = ~clk_in;
  function automatic logic [31:0] memval(input logic [31:0] a);
    return a[31:4] == 28'h100 ? 32'hA0 + {28'h0, a[3:2]} : ~{a[31:2], 2'b00};
  endfunction
  assign mem_ack = mem_req && (auto_ack || man_ack);
  assign mem_data = junk ? 32'hDEAD_BEEF : memval(mem_addr);
  set_assoc_icache #(.IndexBit(4), .OffsetBit(2), .Ways(2)) u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .fetch_valid(fetch_valid),
    .fetch_addr(fetch_addr), .hit(hit), .fetch_inst(fetch_inst), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data)
  );
  set_assoc_icache #(.IndexBit(4), .OffsetBit(2), .Ways(1)) u_one (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(1'b1), .fetch_valid(f1_valid),
    .fetch_addr(f1_addr), .hit(hit1), .fetch_inst(inst1), .flush(1'b0),
    .mem_req(req1), .mem_addr(addr1), .mem_ack(req1), .mem_data(memval(addr1))
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int mway(input logic [31:0] a);
    for (int w = 0; w < 2; w++) if (mv[w][a[7:4]] && mt[w][a[7:4]] == a[31:8]) return w;
    return -1;
  endfunction
  function automatic bit mvictim(input logic [3:0] s);
    return !mv[0][s] ? 1'b0 : !mv[1][s] ? 1'b1 : ml[s];
  endfunction
  function automatic bit exp_hit();
    return fetch_valid && !mref && mway(fetch_addr) >= 0;
  endfunction
  function automatic logic [31:0] exp_inst();
    return exp_hit() ? md[mway(fetch_addr)][fetch_addr[7:4]][fetch_addr[3:2]] : 32'h0;
  endfunction
  always @(posedge clk_in) if (mem_ack && rdy_in && !flush) acks <= acks + 1;
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int w = 0; w < 2; w++) for (int s = 0; s < 16; s++) mv[w][s] <= 1'b0;
      for (int s = 0; s < 16; s++) ml[s] <= 1'b0;
      mref <= 1'b0;
    end else if (rdy_in) begin
      if (flush) begin
        for (int w = 0; w < 2; w++) for (int s = 0; s < 16; s++) mv[w][s] <= 1'b0;
        mref <= 1'b0;
      end else if (!mref) begin
        if (fetch_valid && mway(fetch_addr) >= 0) begin
          ml[fetch_addr[7:4]] <= mway(fetch_addr) == 0;
        end else if (fetch_valid) begin
          mvic <= mvictim(fetch_addr[7:4]);
          mv[mvictim(fetch_addr[7:4])][fetch_addr[7:4]] <= 1'b0;
          mref <= 1'b1;
          mbase <= {fetch_addr[31:4], 4'h0};
          mcnt <= 0;
        end
      end else if (mem_ack) begin
        md[mvic][mbase[7:4]][mcnt] <= mem_data;
        if (mcnt == 3) begin
          mv[mvic][mbase[7:4]] <= 1'b1;
          mt[mvic][mbase[7:4]] <= mbase[31:8];
          ml[mbase[7:4]] <= !mvic;
          mref <= 1'b0;
        end else begin
          mcnt <= mcnt + 1;
        end
      end
    end
  end
  always @(negedge clk_in) begin
    if (!rst_in) begin
      chk("cyc_hit", {31'h0, hit}, {31'h0, exp_hit()});
      chk("cyc_inst", fetch_inst, exp_inst());
      chk("cyc_mem_req", {31'h0, mem_req}, {31'h0, mref});
      if (mref) chk("cyc_mem_addr", mem_addr, mbase + 32'(mcnt * 4));
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask
  task automatic wait_hit(output int n);
    n = 0;
    #1;
    while (!hit && n < 40) begin
      tick(1);
      #1;
      n++;
    end
  endtask
  task automatic fetch(input logic [31:0] a, input int exp_n, input logic [31:0] exp_i);
    int n;
    fetch_addr = a;
    fetch_valid = 1'b1;
    wait_hit(n);
    chk("latency", n, exp_n);
    chk("inst", fetch_inst, exp_i);
    tick(1);
    fetch_valid = 1'b0;
  endtask
  initial begin
    int n;
    logic [31:0] a;
    fetch_valid = 1'b1;
    fetch_addr = 32'h1000;
    #1;
    chk("rst_hit", {31'h0, hit}, 0);
    chk("rst_inst", fetch_inst, 0);
    chk("rst_req", {31'h0, mem_req}, 0);
    chk("rst_addr", mem_addr, 0);
    fetch_valid = 1'b0;
    tick(2);
    rst_in = 1'b0;
    tick(1);
    fetch(32'h1000, 5, 32'hA0);
    chk("cold_acks", acks, 4);
    fetch(32'h1008, 0, 32'hA2);
    fetch(32'h2000, 5, 32'hFFFF_DFFF);
    fetch(32'h1000, 0, 32'hA0);
    fetch(32'h2000, 0, 32'hFFFF_DFFF);
    fetch(32'h1000, 0, 32'hA0);
    fetch(32'h3000, 5, 32'hFFFF_CFFF);
    fetch(32'h1000, 0, 32'hA0);
    fetch(32'h2000, 5, 32'hFFFF_DFFF);
    auto_ack = 1'b0;
    fetch_addr = 32'h4000;
    fetch_valid = 1'b1;
    tick(1);
    fetch_valid = 1'b0;
    chk("flush_req_on", {31'h0, mem_req}, 1);
    man_ack = 1'b1;
    tick(2);
    flush = 1'b1;
    tick(1);
    chk("flush_req_off", {31'h0, mem_req}, 0);
    flush = 1'b0;
    man_ack = 1'b0;
    auto_ack = 1'b1;
    fetch(32'h1000, 5, 32'hA0);
    fetch(32'h2000, 5, 32'hFFFF_DFFF);
    fetch_addr = 32'h5000;
    fetch_valid = 1'b1;
    tick(2);
    rdy_in = 1'b0;
    junk = 1'b1;
    tick(3);
    chk("frozen_addr", mem_addr, 32'h5004);
    chk("frozen_req", {31'h0, mem_req}, 1);
    rdy_in = 1'b1;
    junk = 1'b0;
    wait_hit(n);
    chk("resume_lat", n, 3);
    chk("resume_inst", fetch_inst, 32'hFFFF_AFFF);
    tick(1);
    fetch_valid = 1'b0;
    fetch(32'h500C, 0, 32'hFFFF_AFF3);
    fetch_addr = 32'h6000;
    fetch_valid = 1'b1;
    tick(2);
    #1;
    rst_in = 1'b1;
    #1;
    chk("arst_req", {31'h0, mem_req}, 0);
    chk("arst_hit", {31'h0, hit}, 0);
    fetch_valid = 1'b0;
    tick(1);
    rst_in = 1'b0;
    fetch(32'h500C, 5, 32'hFFFF_AFF3);
    for (int i = 0; i < 4; i++) begin
      a = i[0] ? 32'h2000 : 32'h1000;
      f1_addr = a;
      f1_valid = 1'b1;
      n = 0;
      #1;
      while (!hit1 && n < 40) begin
        tick(1);
        #1;
        n++;
      end
      chk("w1_latency", n, 5);
      chk("w1_inst", inst1, i[0] ? 32'hFFFF_DFFF : 32'hA0);
      tick(1);
    end
    f1_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
